dvp_pixel_assembler: RTL and testbench

DVP_PIXEL_ASSEMBLER -- requirements
Module: dvp_pixel_assembler

---
 rtl/dvp_pixel_assembler.sv | 161 ++++++++++++++++
 tb/tb_dvp_pixel_assembler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dvp_pixel_assembler.sv
// dvp_pixel_assembler
//   Assembles RGB565 pixels from an 8-bit DVP camera byte stream. The high
//   byte arrives first. Emitted pixels carry registered column/row
//   coordinates. Capture arms only after the first vsync rising edge seen
//   after reset. Any frame already in flight at reset is discarded.
//
// Parameters
//   H_ACTIVE : active pixels per line
//   V_ACTIVE : active lines per frame
//
// Ports
//   clk         in   camera pixel clock, the only clock (rising edge)
//   reset       in   asynchronous active-low reset
//   cam_data    in   DVP byte bus
//   href        in   line valid, bytes valid while high
//   vsync       in   frame sync, active-high pulse between frames
//   pixel       out  assembled RGB565 pixel
//   pixel_valid out  one-cycle strobe qualifying pixel/x/y
//   x, y        out  coordinates of the strobed pixel
//   frame_start out  high with pixel_valid for pixel (0,0) only
//   frame_done  out  pulse on the vsync rise that ends a complete frame
//   line_err    out  sticky line-length error
//
// Optional feature
//   DVP_LINE_CHECK_EN : when defined, line_err flags any captured line whose
//   byte count is not 2*H_ACTIVE. Otherwise line_err is tied to 0.
module dvp_pixel_assembler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cam_data,
  input  logic        href,
  input  logic        vsync,
  output logic [15:0] pixel,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err
);

  typedef enum logic [1:0] {WAIT_SYNC, WAIT_LINE, CAPTURE} state_t;

  localparam logic [9:0] H_MAX = 10'(H_ACTIVE);
  localparam logic [8:0] V_MAX = 9'(V_ACTIVE);

  state_t     state;
  logic       vsync_q;
  logic       phase;        // 0: expecting high byte, 1: expecting low byte
  logic [7:0] hi_byte;
  logic [9:0] x_cnt;        // next column; saturates at H_ACTIVE
  logic [8:0] y_cnt;        // current row; saturates at V_ACTIVE
  logic       line_has_px;  // a pixel was emitted on the current line

  logic vs_rise;
  logic sample;

  assign vs_rise = vsync & ~vsync_q;

  // Bytes are taken in CAPTURE, and also on the WAIT_LINE -> CAPTURE edge
  // itself, so the first byte of a line is not lost. vsync high blocks
  // sampling outright.
  assign sample = href & ~vsync &
                  ((state == CAPTURE) ||
                   ((state == WAIT_LINE) && (y_cnt < V_MAX)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_SYNC;
      vsync_q     <= 1'b0;
      phase       <= 1'b0;
      hi_byte     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      line_has_px <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (vs_rise) begin
        // A new frame starts from any state. A line in progress is aborted.
        state       <= WAIT_LINE;
        x_cnt       <= '0;
        y_cnt       <= '0;
        phase       <= 1'b0;
        line_has_px <= 1'b0;
        frame_done  <= (y_cnt == V_MAX);
      end else begin
        case (state)
          WAIT_LINE: if (sample) state <= CAPTURE;
          CAPTURE: begin
            if (!href) begin
              // End of line. A pending odd byte is dropped with the phase.
              state       <= WAIT_LINE;
              phase       <= 1'b0;
              line_has_px <= 1'b0;
              if (line_has_px) begin
                x_cnt <= '0;
                if (y_cnt < V_MAX) y_cnt <= y_cnt + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end

      if (sample) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= cam_data;
        end else if (x_cnt < H_MAX) begin
          pixel       <= {hi_byte, cam_data};
          pixel_valid <= 1'b1;
          x           <= x_cnt;
          y           <= y_cnt;
          frame_start <= (x_cnt == '0) && (y_cnt == '0);
          x_cnt       <= x_cnt + 10'd1;
          line_has_px <= 1'b1;
        end
      end
    end
  end

`ifdef DVP_LINE_CHECK_EN
  // Byte counter saturates one past the nominal length. A line that is too
  // long then stays distinguishable from a line of exactly the right length.
  localparam int            BCW    = $clog2(2*H_ACTIVE + 2);
  localparam logic [BCW-1:0] B_FULL = BCW'(2*H_ACTIVE);
  localparam logic [BCW-1:0] B_SAT  = BCW'(2*H_ACTIVE + 1);

  logic [BCW-1:0] byte_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      line_err <= 1'b0;
    end else if (vs_rise) begin
      byte_cnt <= '0;
    end else if ((state == CAPTURE) && !href) begin
      byte_cnt <= '0;
      if (byte_cnt != B_FULL) line_err <= 1'b1;
    end else if (sample && (byte_cnt != B_SAT)) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_pixel_assembler.sv
// Directed bench for dvp_pixel_assembler on a reduced 8x4 frame.
// Expected pixel stream, coordinates and flags come from a small behavioural
// model driven alongside the stimulus.
module tb_dvp_pixel_assembler;

  localparam int H = 8;
  localparam int V = 4;
`ifdef DVP_LINE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        href = 1'b0;
  logic        vsync = 1'b0;
  logic [15:0] pixel;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;

  int n_vec = 0;
  int n_err = 0;
  int bc    = 0;     // bytes driven on current line
  int exp_y = 0;
  bit armed = 1'b0;  // a vsync edge has been seen since reset
  bit exp_err = 1'b0;
  bit any_px = 1'b0;

  always #5 clk = ~clk;

  dvp_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .cam_data(cam_data), .href(href),
    .vsync(vsync), .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {pixel, pixel_valid, x, y, frame_start, frame_done, line_err}, 64'd0);
  endtask

  task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1);
    bit ev;
    int k;
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      cam_data = (bc % 2 == 0) ? b0 : b1;
      tick;
      k  = bc / 2;
      ev = armed && (exp_y < V) && (bc % 2 == 1) && (k < H);
      chk("pixel_valid", pixel_valid, ev);
      chk("frame_start", frame_start, ev && (k == 0) && (exp_y == 0));
      if (ev) begin
        chk("pixel", pixel, {b0, b1});
        chk("x", x, k);
        chk("y", y, exp_y);
        any_px = 1'b1;
      end
      bc++;
    end
  endtask

  task automatic end_line;
    if (armed && (exp_y < V) && (bc > 0) && (bc != 2*H)) exp_err = CHK;
    href = 1'b0;
    cam_data = '0;
    tick;
    chk("pv_at_href_fall", pixel_valid, 1'b0);
    chk("line_err", line_err, exp_err);
    if (any_px && exp_y < V) exp_y++;
    bc = 0;
    any_px = 1'b0;
    tick;
  endtask

  task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1);
    send_bytes(n, b0, b1);
    end_line;
  endtask

  task automatic vs_pulse(input bit exp_fd);
    vsync = 1'b1;
    tick;
    chk("frame_done", frame_done, exp_fd);
    tick;
    chk("frame_done_width", frame_done, 1'b0);
    vsync = 1'b0;
    tick;
    armed = 1'b1;
    exp_y = 0;
    bc = 0;
    any_px = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk_zero("reset_outputs");
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk_zero("after_release");

    // Lines before any vsync: nothing captured
    send_line(2*H, 8'hF8, 8'h1F);

    // First vsync after reset: no frame_done
    vs_pulse(1'b0);

    // Full 4-line frame, one odd-length line, one ignored extra line
    send_line(2*H,     8'hF8, 8'h1F);   // y=0
    send_line(2*H,     8'hF8, 8'h1F);   // y=1
    send_line(2*H + 1, 8'hF8, 8'h1F);   // y=2, odd byte dropped
    send_line(2*H,     8'h12, 8'h34);   // y=3, starts at phase 0
    send_line(2*H,     8'h55, 8'hAA);   // y=V, ignored
    vs_pulse(1'b1);                     // complete frame

    // vsync mid-line aborts the frame without frame_done
    send_line(2*H, 8'hF8, 8'h1F);       // y=0
    send_bytes(5, 8'h9A, 8'hBC);        // y=1, x=0,1 then half a pixel
    vsync = 1'b1;                       // high with href: no byte sampled
    cam_data = 8'hBC;
    tick;
    chk("pv_vsync_wins", pixel_valid, 1'b0);
    chk("frame_done_abort", frame_done, 1'b0);
    vsync = 1'b0;
    href = 1'b0;
    tick;
    chk("pv_after_abort", pixel_valid, 1'b0);
    exp_y = 0;
    bc = 0;
    any_px = 1'b0;
    tick;
    send_line(2*H, 8'h07, 8'hE0);       // restarts at (0,0)

    // Asynchronous reset in the middle of a line
    send_bytes(8, 8'hAB, 8'hCD);        // y=1; strobe is high right now
    reset = 1'b0;
    #1;
    chk_zero("async_reset_immediate");
    tick;
    chk_zero("reset_held");
    reset = 1'b1;
    armed = 1'b0;
    exp_err = 1'b0;
    exp_y = 0;
    send_bytes(8, 8'hAB, 8'hCD);        // href continues: must stay quiet
    end_line;
    vs_pulse(1'b0);
    send_line(2*H, 8'hF8, 8'h1F);       // pixel at (0,0) again

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
